// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the sequence decoder.
//   state_e     : controller states (IDLE, DIRECT, SCAN).
//   MODE_DIRECT : value of the mode input that selects direct decode.
//   MODE_SCAN   : value of the mode input that selects auto-scan.
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// Combinational binary-to-one-hot decoder.
//   sel_in  : SEL_W-bit binary index.
//   dec_out : OUT_W-bit one-hot result; bit sel_in is set.
// Each output bit is a plain equality compare, so every input value
// yields a defined one-hot word.
module onehot_dec #(
  parameter  int SEL_W = 2,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel_in,
  output logic [OUT_W-1:0] dec_out
);

  always_comb begin
    dec_out = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dec_out[i] = (sel_in == SEL_W'(i));
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Sequence decoder: drives a registered one-hot output either directly
// from sel (DIRECT) or by stepping through all positions with a
// programmable dwell time (SCAN).
//   clk       : rising-edge clock.
//   rst_n     : asynchronous active-low reset.
//   enable    : block enable; low forces IDLE with all outputs zero.
//   mode      : 0 direct, 1 scan; sampled only with load.
//   load      : command strobe capturing mode, sel and dwell.
//   sel       : direct select or scan start index.
//   dwell     : cycles per scan position (0 behaves as 1).
//   out       : registered one-hot (or zero) output.
//   out_valid : out is non-zero.
//   wrap      : one-cycle pulse when the scan index wraps to 0.
//   busy      : controller is in SCAN.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter  int SEL_W   = 2,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               wrap,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [SEL_W-1:0]   dec_in;
  logic [OUT_W-1:0]   dec_out;

  // A zero dwell is stored as 1 so the reload value dwell_q-1 never underflows.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // The single decoder sees the index of the state being entered, so out
  // always reflects the next state with exactly one register of latency.
  assign dec_in = (state_d == ST_SCAN) ? idx_d : sel;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel_in  (dec_in),
    .dec_out (dec_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;

    if (!enable) begin
      // Disable wins over load and throws away any scan context.
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      dwell_d = '0;
    end else if (load && (mode == MODE_SCAN)) begin
      state_d = ST_SCAN;
      idx_d   = sel;
      dwell_d = dwell_eff;
      cnt_d   = dwell_eff - DWELL_W'(1);
    end else if (load) begin
      state_d = ST_DIRECT;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_DIRECT;
        ST_SCAN: begin
          if (cnt_q == '0) begin
            idx_d  = idx_q + SEL_W'(1);
            cnt_d  = dwell_q - DWELL_W'(1);
            wrap_d = (idx_q == '1);
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        default: ;
      endcase
    end

    out_d       = (state_d == ST_IDLE) ? '0 : dec_out;
    out_valid_d = |out_d;
    busy_d      = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_seq_decoder;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;
  localparam int OUT_W   = 1 << SEL_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               wrap;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: position shown, cycles left at that position,
  // and the hold length captured at the last scan load.
  bit m_scan;
  int m_pos;
  int m_left;
  int m_hold;
  int m_out;
  bit m_wrap;

  seq_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .load      (load),
    .sel       (sel),
    .dwell     (dwell),
    .out       (out),
    .out_valid (out_valid),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_scan = 1'b0;
    m_pos  = 0;
    m_left = 0;
    m_hold = 0;
    m_out  = 0;
    m_wrap = 1'b0;
  endtask

  // One clock edge of the specified behaviour, given the sampled inputs.
  task automatic modelStep(input bit en, input bit ld, input bit md,
                           input int s, input int dw);
    m_wrap = 1'b0;
    if (!en) begin
      m_scan = 1'b0;
      m_out  = 0;
    end else if (ld && md) begin
      m_scan = 1'b1;
      m_pos  = s;
      m_hold = (dw == 0) ? 1 : dw;
      m_left = m_hold;
      m_out  = 1 << m_pos;
    end else if (ld || !m_scan) begin
      m_scan = 1'b0;
      m_out  = 1 << s;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_pos  = (m_pos + 1) % OUT_W;
        m_left = m_hold;
        m_wrap = (m_pos == 0);
      end
      m_out = 1 << m_pos;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_out"},   64'(out),       64'(m_out));
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(m_out != 0));
    checkOutput({tag, "_wrap"},  64'(wrap),      64'(m_wrap));
    checkOutput({tag, "_busy"},  64'(busy),      64'(m_scan));
  endtask

  // Drive inputs mid-cycle, let one rising edge pass, then check #1 later.
  task automatic applyStimulus(input bit en, input bit ld, input bit md,
                               input int s, input int dw, input string tag);
    enable = en;
    load   = ld;
    mode   = md;
    sel    = SEL_W'(s);
    dwell  = DWELL_W'(dw);
    @(posedge clk);
    modelStep(en, ld, md, s, dw);
    #1;
    checkAll(tag);
  endtask

  initial begin
    int exp033[10];
    int exp037[4];
    exp033 = '{4, 4, 4, 8, 8, 8, 1, 1, 1, 2};
    exp037 = '{1, 1, 2, 2};

    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = 1'b0;
    load   = 1'b0;
    sel    = '0;
    dwell  = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst_n = 1'b1;

    // Direct decode, sel stepping every cycle.
    for (int i = 0; i < OUT_W; i++) applyStimulus(1, 0, 0, i, 0, "direct");
    for (int i = OUT_W - 1; i >= 0; i--) applyStimulus(1, 0, 0, i, 7, "direct_rev");

    // Scan from 2 with dwell 3; dwell input wiggles to prove it is latched.
    applyStimulus(1, 1, 1, 2, 3, "scan3");
    checkOutput("scan3_seq_out", 64'(out), 64'(exp033[0]));
    checkOutput("scan3_seq_wrap", 64'(wrap), 64'(0));
    for (int i = 1; i < 10; i++) begin
      applyStimulus(1, 0, 0, 0, i % 5, "scan3");
      checkOutput("scan3_seq_out", 64'(out), 64'(exp033[i]));
      checkOutput("scan3_seq_wrap", 64'(wrap), 64'(i == 6));
    end

    // Mid-scan disable together with load: disable wins.
    applyStimulus(1, 1, 1, 1, 2, "dis_scan");
    applyStimulus(1, 0, 0, 0, 0, "dis_scan");
    applyStimulus(0, 1, 1, 3, 4, "dis_load");
    checkOutput("dis_load_busy_const", 64'(busy), 64'(0));
    applyStimulus(1, 0, 0, 2, 0, "dis_after");

    // Asynchronous reset pulse between edges during a scan.
    applyStimulus(1, 1, 1, 0, 4, "rst_scan");
    applyStimulus(1, 0, 0, 0, 4, "rst_scan");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("rst_async");
    #1 rst_n = 1'b1;
    applyStimulus(1, 0, 0, 1, 0, "rst_after");
    applyStimulus(1, 0, 0, 3, 0, "rst_after");

    // Restart mid-scan: sel 3 dwell 5, reload at cycle 2 with sel 0 dwell 2.
    applyStimulus(1, 1, 1, 3, 5, "restart");
    applyStimulus(1, 0, 0, 0, 0, "restart");
    applyStimulus(1, 1, 1, 0, 2, "restart");
    checkOutput("restart_seq_out", 64'(out), 64'(exp037[0]));
    checkOutput("restart_seq_wrap", 64'(wrap), 64'(0));
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, "restart");
      checkOutput("restart_seq_out", 64'(out), 64'(exp037[i]));
    end

    // Dwell 0 scan advances every cycle and wraps every OUT_W cycles.
    applyStimulus(1, 1, 1, 0, 0, "dwell0");
    for (int i = 0; i < 3 * OUT_W; i++) applyStimulus(1, 0, 0, 0, 9, "dwell0");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 19) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, OUT_W - 1)),
                    int'($urandom_range(0, 5)),
                    "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
